// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: merges ALU/load results into an in-order write FIFO, drains one register-file write per cycle, forwards pending data.
module rf_writeback_ctrl #(
  parameter int reg_addr_width = 5,
  parameter int reg_data_width = 32,
  parameter int fifo_depth = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_valid,
  input  logic [reg_addr_width-1:0]         alu_rd,
  input  logic [reg_data_width-1:0]         alu_data,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic [reg_addr_width-1:0]         ld_rd,
  input  logic [reg_data_width-1:0]         ld_data,
  input  logic                              wb_hold,
  output logic [reg_addr_width-1:0]         wr_addr,
  output logic [reg_data_width-1:0]         wr_data,
  output logic                              write_back_en,
  input  logic [reg_addr_width-1:0]         q_addr1,
  input  logic [reg_addr_width-1:0]         q_addr2,
  output logic                              fwd_hit1,
  output logic                              fwd_hit2,
  output logic [reg_data_width-1:0]         fwd_data1,
  output logic [reg_data_width-1:0]         fwd_data2,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic [$clog2(fifo_depth):0]       count,
  output logic                              overflow_err
);
  localparam int pw = $clog2(fifo_depth);
  localparam int cw = pw + 1;
  logic [reg_addr_width-1:0] addr_mem [fifo_depth];
  logic [reg_data_width-1:0] data_mem [fifo_depth];
  logic [pw-1:0] head, tail;
  logic [reg_addr_width-1:0] in_rd;
  logic [reg_data_width-1:0] in_data;
  logic push, pop;
  logic [reg_addr_width-1:0] q [2];
  logic hit [2];
  logic [reg_data_width-1:0] fd [2];
  assign fifo_empty = count == '0;
  assign fifo_full = count == cw'(fifo_depth);
  assign ld_ready = !alu_valid && !fifo_full;
  assign in_rd = alu_valid ? alu_rd : ld_rd;
  assign in_data = alu_valid ? alu_data : ld_data;
  // x0 writes complete their handshake but never occupy an entry
  assign push = (alu_valid || (ld_valid && ld_ready)) && !fifo_full && in_rd != '0;
  assign pop = !fifo_empty && !wb_hold;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      head <= '0;
      tail <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      write_back_en <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      count <= count + cw'(push) - cw'(pop);
      write_back_en <= pop;
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head <= head + 1'b1;
        wr_addr <= addr_mem[head];
        wr_data <= data_mem[head];
      end
      if (alu_valid && fifo_full) overflow_err <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) begin
      addr_mem[tail] <= in_rd;
      data_mem[tail] <= in_data;
    end
  assign q[0] = q_addr1;
  assign q[1] = q_addr2;
  // scan oldest to newest so the youngest match wins; output register is older than any entry
  always_comb
    for (int p = 0; p < 2; p++) begin
      hit[p] = write_back_en && wr_addr == q[p];
      fd[p] = hit[p] ? wr_data : '0;
      for (int k = 0; k < fifo_depth; k++) begin
        logic [pw-1:0] idx;
        idx = head + pw'(k);
        if (cw'(k) < count && addr_mem[idx] == q[p]) begin
          hit[p] = 1'b1;
          fd[p] = data_mem[idx];
        end
      end
      if (q[p] == '0) begin
        hit[p] = 1'b0;
        fd[p] = '0;
      end
    end
  assign fwd_hit1 = hit[0];
  assign fwd_hit2 = hit[1];
  assign fwd_data1 = fd[0];
  assign fwd_data2 = fd[1];
endmodule
